// File: rtl/imem_loader.sv
// Instruction-memory loader: takes a byte stream with a 16-bit word-count header, packs it
// MSB-first into 32-bit words, writes them at consecutive word addresses and holds the CPU until done.
module imem_loader #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] ADDR_BASE   = 32'h0
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [7:0]  ByteIn,
    input  logic        ByteValid,
    output logic        ByteReady,
    output logic        MemWrEn,
    output logic [31:0] MemWrAddr,
    output logic [31:0] MemWrData,
    output logic        CpuHold,
    output logic        Done,
    output logic        Error
);
    typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, RECV, WRITE, DONE} state_t;

    localparam logic [16:0] DEPTH_L = 17'(DEPTH_WORDS);

    state_t      state;
    logic [1:0]  byte_idx;
    logic [15:0] word_cnt;
    logic [15:0] length;
    logic [23:0] word_hi;

    logic        xfer;
    logic [15:0] hdr_len;
    logic [15:0] cnt_next;
    logic [31:0] wr_addr;

    assign xfer     = ByteValid & ByteReady;
    assign hdr_len  = {length[15:8], ByteIn};
    assign cnt_next = word_cnt + 16'd1;
    assign wr_addr  = ADDR_BASE + {14'd0, word_cnt, 2'b00};

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= IDLE;
            byte_idx  <= 2'd0;
            word_cnt  <= 16'd0;
            length    <= 16'd0;
            word_hi   <= 24'd0;
            ByteReady <= 1'b0;
            MemWrEn   <= 1'b0;
            MemWrAddr <= ADDR_BASE;
            MemWrData <= 32'd0;
            CpuHold   <= 1'b1;
            Done      <= 1'b0;
            Error     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        state     <= HDR_HI;
                        ByteReady <= 1'b1;
                        Done      <= 1'b0;
                        Error     <= 1'b0;
                        CpuHold   <= 1'b1;
                        word_cnt  <= 16'd0;
                        byte_idx  <= 2'd0;
                    end
                end
                HDR_HI: begin
                    if (xfer) begin
                        length[15:8] <= ByteIn;
                        state        <= HDR_LO;
                    end
                end
                HDR_LO: begin
                    if (xfer) begin
                        length   <= hdr_len;
                        byte_idx <= 2'd0;
                        // Empty or oversized images finish without touching memory.
                        if (hdr_len == 16'd0 || {1'b0, hdr_len} > DEPTH_L) begin
                            state     <= DONE;
                            ByteReady <= 1'b0;
                            Done      <= 1'b1;
                            CpuHold   <= 1'b0;
                            Error     <= (hdr_len != 16'd0);
                        end else begin
                            state <= RECV;
                        end
                    end
                end
                RECV: begin
                    if (xfer) begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_hi[23:16] <= ByteIn;
                            2'd1: word_hi[15:8]  <= ByteIn;
                            2'd2: word_hi[7:0]   <= ByteIn;
                            default: begin
                                MemWrData <= {word_hi, ByteIn};
                                MemWrAddr <= {wr_addr[31:2], 2'b00};
                                MemWrEn   <= 1'b1;
                                ByteReady <= 1'b0;
                                state     <= WRITE;
                            end
                        endcase
                    end
                end
                WRITE: begin
                    MemWrEn  <= 1'b0;
                    word_cnt <= cnt_next;
                    byte_idx <= 2'd0;
                    if (cnt_next == length) begin
                        state   <= DONE;
                        Done    <= 1'b1;
                        CpuHold <= 1'b0;
                    end else begin
                        state     <= RECV;
                        ByteReady <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    ByteReady <= 1'b0;
                end
            endcase
        end
    end
endmodule
